bit_timer_ctrl: RTL
===================

Name: bit_timer_ctrl

Overview:
- Sequencing controller for a rollover-style bit timer used in the serial receive path.
- On `start`, it waits half a bit period to centre on the first bit. It then emits one `shift_strobe` per bit period for a programmed number of bits, followed by a one-cycle `packet_done`.
- It owns its timing counter (clear / enable / rollover target) and latches its configuration, so the receiver shift register and the framing FSM only consume strobes.

Parameters:
- CNT_BITS, 4, width of bit-period counter and `bit_period` port; legal period 2..2^CNT_BITS-1
- IDX_BITS, 4, width of `num_bits` and `bit_idx`; legal bit count 1..2^IDX_BITS-1

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  asynchronous active-low reset
- start  input  1  request to begin a packet; sampled only in IDLE
- abort  input  1  synchronous cancel of an in-progress packet
- bit_period  input  CNT_BITS  clocks per bit; latched on accepted start
- num_bits  input  IDX_BITS  bits per packet; latched on accepted start
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- shift_strobe  output  1  one-cycle pulse at the sample point of each bit
- bit_idx  output  IDX_BITS  index of the bit being sampled; valid while `shift_strobe` is high
- packet_done  output  1  one-cycle pulse after the last strobe
- err_cfg  output  1  one-cycle pulse when `start` is seen with an illegal configuration

Behaviour:
- Reset: state IDLE; `busy`, `shift_strobe`, `packet_done`, `err_cfg` = 0; `bit_idx` = 0; counter = 0; latched configuration = 0.
- States: IDLE, HALF, BIT, DONE. All outputs come from registered state/counter only; there is no combinational path from inputs to outputs.
- IDLE:
  - `start`=1, `abort`=0, `bit_period`>=2 and `num_bits`>=1: latch P=`bit_period` and N=`num_bits`; counter=1; `bit_idx`=0; go to HALF.
  - `start`=1 with P<2 or N=0: stay IDLE; `err_cfg`=1 for the next cycle.
  - `abort` and `start` together in IDLE: `abort` wins; no start, no `err_cfg`.
- HALF: target H = floor(P/2) (P=2 or 3 gives H=1).
  - Counter increments each cycle.
  - `shift_strobe`=1 in the cycle where counter==H; counter reloads to 1 on the next edge and the state moves to BIT, or to DONE if N=1.
- BIT: target P.
  - `shift_strobe`=1 when counter==P; the counter reloads to 1 and `bit_idx` increments on that edge.
  - Go to DONE when the strobe fires with `bit_idx`==N-1.
- DONE: exactly one cycle; `packet_done`=1, `busy`=1, `shift_strobe`=0. Next state IDLE with `bit_idx` cleared to 0.
- Timing, with `start` sampled at edge 0 (cycle 1 = first busy cycle):
  - Strobe k (k=0..N-1) fires in cycle H + k·P.
  - `packet_done` fires in cycle H+(N-1)·P+1.
  - `busy` falls in the following cycle.
- `start` is ignored while not in IDLE. `start` in the DONE cycle is also ignored.
- Configuration inputs are ignored after latching; changing them mid-packet has no effect.
- `abort`=1 in HALF/BIT/DONE: next state IDLE; `busy`=0 next cycle; `bit_idx`=0.
  - No further strobe is issued and `packet_done` is never pulsed for an aborted packet.
  - A strobe already high in the abort cycle is still valid, because outputs are registered-state decodes.
- Counter width arithmetic: the counter never exceeds P, so no wrap occurs. The maximum P (all ones) must work without overflow, including the counter==P compare.
- Reset asserted mid-packet forces the reset state immediately, with no `packet_done`.

Test Plan:
- P=4, N=3, `start` pulsed one cycle → `busy` 1 in cycles 1–11; strobes in cycles 2, 6, 10 with `bit_idx`=0, 1, 2; `packet_done` in cycle 11 only; `busy`=0 in cycle 12.
- P=3, N=1 → strobe in cycle 1 (`bit_idx`=0); `packet_done` in cycle 2; back in IDLE in cycle 3.
- P=15 (max, CNT_BITS=4), N=15 → first strobe in cycle 7, then every 15 cycles; last strobe `bit_idx`=14 in cycle 217; `packet_done` in cycle 218.
- `start` with P=1, then `start` with N=0 → `err_cfg` one-cycle pulse each time; `busy`, `shift_strobe` and `packet_done` stay 0.
- P=4, N=3, `abort` in cycle 5 → strobe in cycle 2 only; `busy`=0 from cycle 6; no `packet_done`. An immediate new `start` is accepted and the timing restarts from cycle 1.
- Mid-packet changes to `bit_period`/`num_bits`, plus `start` re-pulsed while busy → timing matches the latched P/N exactly. Asserting `n_rst` low in cycle 4 clears all outputs asynchronously.

Source files
------------

// File: rtl/bit_timer_ctrl.sv
// bit_timer_ctrl: sequencing controller for a rollover bit timer.
// After an accepted start it waits half a bit period, then emits one
// shift_strobe per bit period for the latched bit count, and ends each
// packet with a one-cycle packet_done.
//
// Interface contract: start is a level request that is only accepted in
// IDLE (abort has priority over it). shift_strobe, packet_done and err_cfg
// are single-cycle pulses that carry no backpressure: consumers must take
// them in the cycle they are high. bit_idx is meaningful only while
// shift_strobe is high.
module bit_timer_ctrl #(
  parameter int CNT_BITS = 4,
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_BITS-1:0] bit_period,
  input  logic [IDX_BITS-1:0] num_bits,
  output logic                busy,
  output logic                shift_strobe,
  output logic [IDX_BITS-1:0] bit_idx,
  output logic                packet_done,
  output logic                err_cfg
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [IDX_BITS-1:0] IDX_ONE = IDX_BITS'(1);

  typedef enum logic [1:0] {IDLE, HALF, BIT, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic [CNT_BITS-1:0] period_q;
  logic [IDX_BITS-1:0] nbits_q;
  logic [IDX_BITS-1:0] idx_q, idx_nxt;
  logic                err_q, err_nxt;
  logic                latch_cfg;

  // Config is legal when period >= 2 (some bit above bit 0 set) and count >= 1.
  logic                cfg_ok;
  logic [CNT_BITS-1:0] half_target;
  logic                hit_half;
  logic                hit_bit;
  logic                last_bit;

  assign cfg_ok      = ((bit_period >> 1) != '0) && (num_bits != '0);
  assign half_target = period_q >> 1;
  assign hit_half    = (state == HALF) && (cnt == half_target);
  assign hit_bit     = (state == BIT) && (cnt == period_q);
  assign last_bit    = (idx_q == (nbits_q - IDX_ONE));

  // Outputs are decodes of registered state only; no input reaches them.
  assign busy         = (state != IDLE);
  assign packet_done  = (state == DONE);
  assign shift_strobe = hit_half | hit_bit;
  assign bit_idx      = idx_q;
  assign err_cfg      = err_q;

  // State, counter, bit index and latched configuration registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      period_q <= '0;
      nbits_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx_q <= idx_nxt;
      err_q <= err_nxt;
      if (latch_cfg) begin
        period_q <= bit_period;
        nbits_q  <= num_bits;
      end
    end
  end

  // Next-state logic: start acceptance, half-period wait, per-bit rollover.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx_q;
    err_nxt   = 1'b0;
    latch_cfg = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            latch_cfg = 1'b1;
            cnt_nxt   = CNT_ONE;
            idx_nxt   = '0;
            state_nxt = HALF;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      HALF: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (hit_half) begin
          cnt_nxt   = CNT_ONE;
          idx_nxt   = idx_q + IDX_ONE;
          state_nxt = (nbits_q == IDX_ONE) ? DONE : BIT;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      BIT: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (hit_bit) begin
          // Counter never passes period_q, so period = all ones cannot wrap.
          cnt_nxt = CNT_ONE;
          idx_nxt = idx_q + IDX_ONE;
          if (last_bit) begin
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule
